// File: rtl/fp_pkg.sv
// Shared constants, mantissa bit positions and FSM state type for the FP adder back end.
package fp_pkg;

   localparam int unsigned EXP_W    = 8;
   localparam int unsigned FRAC_W   = 23;
   localparam int unsigned MANT_W   = FRAC_W + 5;
   // Two guard bits so exponent increments and decrements never wrap.
   localparam int unsigned EXP_IW   = EXP_W + 2;
   localparam int unsigned EXP_MAX  = 255;
   localparam int unsigned BIAS     = 127;

   localparam int unsigned CARRY_B  = 27;
   localparam int unsigned HIDDEN_B = 26;
   localparam int unsigned GUARD_B  = 2;
   localparam int unsigned LSB_B    = GUARD_B + 1;

   typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

endpackage

// File: rtl/fp_norm_round_pack_if.sv
// Input sum and output result handshakes of the normalise/round/pack stage.
interface fp_norm_round_pack_if;
   import fp_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic [EXP_W-1:0]  in_exp;
   logic [MANT_W-1:0] in_mant;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_result;
   logic              out_overflow;
   logic              out_underflow;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_underflow
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_underflow
   );

endinterface

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even on a normalised mantissa, then pack to IEEE-754 single with flags.
module fp_round_pack
   import fp_pkg::*;
(
   input  logic              sign_i,
   input  logic [EXP_IW-1:0] exp_i,
   input  logic [HIDDEN_B:0] mant_i,
   output logic [31:0]       result_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   logic                lsb;
   logic                guard;
   logic                sticky;
   logic                inc;
   logic [FRAC_W+1:0]   sum;
   logic                hidden;
   logic [FRAC_W-1:0]   frac;
   logic [EXP_IW-1:0]   exp_r;

   always_comb begin
      lsb    = mant_i[LSB_B];
      guard  = mant_i[GUARD_B];
      sticky = |mant_i[GUARD_B-1:0];
      inc    = guard & (sticky | lsb);
      sum    = {1'b0, mant_i[HIDDEN_B:LSB_B]} + {{(FRAC_W + 1){1'b0}}, inc};

      // Rounding all-ones carries past the hidden bit: renormalise by one.
      if (sum[FRAC_W+1]) begin
         hidden = 1'b1;
         frac   = sum[FRAC_W:1];
         exp_r  = exp_i + EXP_IW'(1);
      end else begin
         hidden = sum[FRAC_W];
         frac   = sum[FRAC_W-1:0];
         exp_r  = exp_i;
      end

      result_o    = '0;
      overflow_o  = 1'b0;
      underflow_o = 1'b0;
      if (mant_i == '0) begin
         result_o = '0;
      end else if (exp_r >= EXP_IW'(EXP_MAX)) begin
         result_o   = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         overflow_o = 1'b1;
      end else if (!hidden) begin
         result_o    = {sign_i, {EXP_W{1'b0}}, frac};
         underflow_o = 1'b1;
      end else begin
         result_o = {sign_i, exp_r[EXP_W-1:0], frac};
      end
   end

endmodule

// File: rtl/fp_norm_round_pack.sv
// Adder back end: iterative one-bit-per-cycle normalisation, RNE rounding and packing.
module fp_norm_round_pack
   import fp_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   fp_norm_round_pack_if.slave  bus_io
);

   state_e              state_q, state_d;
   logic                sign_q, sign_d;
   logic [EXP_IW-1:0]   exp_q, exp_d;
   logic [MANT_W-1:0]   mant_q, mant_d;
   logic [31:0]         result_q, result_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;

   logic [31:0]         rp_result;
   logic                rp_ovf;
   logic                rp_unf;

   fp_round_pack u_round_pack (
      .sign_i      (sign_q),
      .exp_i       (exp_q),
      .mant_i      (mant_q[HIDDEN_B:0]),
      .result_o    (rp_result),
      .overflow_o  (rp_ovf),
      .underflow_o (rp_unf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mant_q   <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;

      unique case (state_q)
         StIdle: begin
            if (bus_io.in_valid) begin
               sign_d  = bus_io.in_sign;
               exp_d   = {2'b00, bus_io.in_exp};
               mant_d  = bus_io.in_mant;
               state_d = StNorm;
            end
         end
         StNorm: begin
            if (mant_q[CARRY_B]) begin
               // Right shift folds the dropped bit into sticky.
               mant_d  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
               exp_d   = exp_q + EXP_IW'(1);
               state_d = StRound;
            end else if (mant_q == '0) begin
               state_d = StRound;
            end else if (!mant_q[HIDDEN_B] && (exp_q > EXP_IW'(1))) begin
               mant_d = {mant_q[MANT_W-2:0], 1'b0};
               exp_d  = exp_q - EXP_IW'(1);
            end else begin
               state_d = StRound;
            end
         end
         StRound: begin
            result_d = rp_result;
            ovf_d    = rp_ovf;
            unf_d    = rp_unf;
            state_d  = StDone;
         end
         StDone: begin
            if (bus_io.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus_io.in_ready      = (state_q == StIdle);
   assign bus_io.out_valid     = (state_q == StDone);
   assign bus_io.out_result    = result_q;
   assign bus_io.out_overflow  = ovf_q;
   assign bus_io.out_underflow = unf_q;

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Directed bench for fp_norm_round_pack: value-level model plus hand-computed vectors.
module tb_fp_norm_round_pack;
   import fp_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_norm_round_pack_if bus ();

   fp_norm_round_pack dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      int          lat;
   } expect_t;

   expect_t sb[$];
   int checks = 0;
   int errors = 0;
   int since  = 0;
   bit busy   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   // Value-level model: bring the leading one to the hidden position (exponent floor 1),
   // round the 3 dropped bits half-to-even, then classify.
   function automatic expect_t model(input logic s, input logic [7:0] e, input logic [27:0] m0);
      expect_t r;
      logic [31:0] m, keep, rem;
      int ex, p, sh;
      m = {4'b0, m0};
      ex = int'(e);
      r.res = '0;
      r.ovf = 1'b0;
      r.unf = 1'b0;
      r.lat = 3;
      if (m == 0) return r;
      if (m[27]) begin
         m = (m >> 1) | (m & 32'd1);
         ex++;
      end else begin
         p = 0;
         for (int i = 0; i < 28; i++) if (m[i]) p = i;
         sh = 26 - p;
         if (sh > ex - 1) sh = ex - 1;
         if (sh < 0) sh = 0;
         m = m << sh;
         ex -= sh;
         r.lat = 3 + sh;
      end
      keep = m >> 3;
      rem  = m & 32'd7;
      if (rem > 4 || (rem == 4 && keep[0])) keep++;
      if (keep >= 32'h0100_0000) begin
         keep >>= 1;
         ex++;
      end
      if (ex >= 255) begin
         r.res = {s, 8'hFF, 23'h0};
         r.ovf = 1'b1;
      end else if (keep < 32'h0080_0000) begin
         r.res = {s, 8'h00, keep[22:0]};
         r.unf = 1'b1;
      end else begin
         r.res = {s, 8'(ex), keep[22:0]};
      end
      return r;
   endfunction

   // Compare process: model each accepted sum, check every valid output cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         busy = 0;
      end else begin
         if (busy) since++;
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.in_sign, bus.in_exp, bus.in_mant));
            since = 0;
            busy  = 1;
         end
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out_valid: got result 0x%08h expected no output",
                        bus.out_result);
            end else begin
               check("model_result", bus.out_result, sb[0].res);
               check("model_overflow", 32'(bus.out_overflow), 32'(sb[0].ovf));
               check("model_underflow", 32'(bus.out_underflow), 32'(sb[0].unf));
               if (busy) begin
                  check("latency", 32'(since), 32'(sb[0].lat));
                  busy = 0;
               end
               if (bus.out_ready) void'(sb.pop_front());
            end
         end
      end
   end

   task automatic run_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                         input logic [31:0] lit, input logic lovf, input logic lunf,
                         input int hold);
      bit ok;
      logic [31:0] first;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b1;
      bus.in_sign   = s;
      bus.in_exp    = e;
      bus.in_mant   = m;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (bus.out_valid) ok = 1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL out_valid_timeout: got no out_valid expected one for mant 0x%07h", m);
         bus.out_ready = 1'b1;
      end else begin
         check("lit_result", bus.out_result, lit);
         check("lit_overflow", 32'(bus.out_overflow), 32'(lovf));
         check("lit_underflow", 32'(bus.out_underflow), 32'(lunf));
         if (hold > 0) begin
            first = bus.out_result;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_exp   = 8'd50;
            bus.in_mant  = 28'h0000001;
            for (int i = 0; i < hold; i++) begin
               @(negedge clk);
               check("hold_result", bus.out_result, first);
               check("hold_in_ready", 32'(bus.in_ready), 32'd0);
               check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            end
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      bit seen;
      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = '0;
      bus.in_mant   = '0;
      bus.out_ready = 1'b1;
      #2;
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_result", bus.out_result, 32'd0);
      check("reset_overflow", 32'(bus.out_overflow), 32'd0);
      check("reset_underflow", 32'(bus.out_underflow), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_op(1'b0, 8'd127, 28'h8000000, 32'h4000_0000, 1'b0, 1'b0, 0);
      run_op(1'b0, 8'd127, 28'h0000008, 32'h3400_0000, 1'b0, 1'b0, 0);
      run_op(1'b0, 8'd127, 28'h400000C, 32'h3F80_0002, 1'b0, 1'b0, 0);
      run_op(1'b0, 8'd127, 28'h4000004, 32'h3F80_0000, 1'b0, 1'b0, 0);
      run_op(1'b1, 8'd254, 28'h8000000, 32'hFF80_0000, 1'b1, 1'b0, 0);
      run_op(1'b1, 8'd100, 28'h0000000, 32'h0000_0000, 1'b0, 1'b0, 0);
      run_op(1'b0, 8'd1,   28'h0000010, 32'h0000_0002, 1'b0, 1'b1, 0);
      run_op(1'b0, 8'd127, 28'h7FFFFFF, 32'h4000_0000, 1'b0, 1'b0, 0);
      run_op(1'b0, 8'd254, 28'h7FFFFFF, 32'h7F80_0000, 1'b1, 1'b0, 0);
      run_op(1'b0, 8'd1,   28'h3FFFFFC, 32'h0080_0000, 1'b0, 1'b0, 0);
      run_op(1'b0, 8'd5,   28'h0000008, 32'h0000_0010, 1'b0, 1'b1, 0);
      run_op(1'b1, 8'd130, 28'h2000001, 32'hC080_0000, 1'b0, 1'b0, 0);
      run_op(1'b0, 8'd127, 28'h8000018, 32'h4000_0002, 1'b0, 1'b0, 0);
      run_op(1'b0, 8'd127, 28'h8000009, 32'h4000_0001, 1'b0, 1'b0, 0);
      run_op(1'b0, 8'd128, 28'h4000000, 32'h4000_0000, 1'b0, 1'b0, 10);

      // Abort a long normalisation with reset; nothing may emerge afterwards.
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_sign  = 1'b0;
      bus.in_exp   = 8'd127;
      bus.in_mant  = 28'h0000008;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1;
      end
      check("no_stale_result", 32'(seen), 32'd0);

      run_op(1'b0, 8'd127, 28'h8000000, 32'h4000_0000, 1'b0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
